// File: rtl/lwc_pkg.sv
// lwc_pkg: shared types and constants for the UART command sequencer.
package lwc_pkg;
    typedef enum logic [2:0] {CMD, KEY, TEXT, WAIT, OUTPUT} state_t;
    localparam logic [7:0] CMD_SIMON = 8'h01;
    localparam logic [7:0] CMD_SPECK = 8'h02;
    localparam int WORD_W = 16;
endpackage

// File: rtl/result_serializer.sv
// result_serializer: streams a 32-bit result as four UART bytes with a valid/ready handshake.
module result_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] result,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        done
);
    logic [31:0] sr;
    logic [1:0]  idx;
    assign tx_byte = sr[7:0];
    assign done    = tx_valid && tx_ready && idx == 2'd3;
    // Word order swapped on load so a plain right shift yields high word first, LSB byte first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr       <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            sr       <= {result[15:0], result[31:16]};
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            sr       <= sr >> 8;
            idx      <= idx + 1'b1;
            tx_valid <= idx != 2'd3;
        end
    end
endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: parses cmd/key/text frames from UART bytes, starts the cipher and streams the result back.
module uart_cmd_sequencer
    import lwc_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned N_KEY_WORDS    = 4,
    parameter int unsigned N_TEXT_WORDS   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_byte,
    output logic [7:0]                       cmd,
    output logic [N_KEY_WORDS*WORD_W-1:0]    key,
    output logic [N_TEXT_WORDS*WORD_W-1:0]   text,
    output logic                             start,
    input  logic                             core_done,
    input  logic [31:0]                      core_result,
    output logic [7:0]                       tx_byte,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             led_input_commande,
    output logic                             led_key_input,
    output logic                             led_text_input,
    output logic                             led_wait_result,
    output logic                             led_output_result,
    output logic                             overrun
);
    // An inter-byte gap is never allowed to exceed one second.
    localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES < CLK_HZ) ? TIMEOUT_CYCLES : CLK_HZ;
    localparam int TO_W = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
    localparam int MAX_B = 2 * ((N_KEY_WORDS > N_TEXT_WORDS) ? N_KEY_WORDS : N_TEXT_WORDS);
    localparam int BC_W = $clog2(MAX_B);
    localparam logic [BC_W-1:0] KEY_LAST  = BC_W'(2 * N_KEY_WORDS - 1);
    localparam logic [BC_W-1:0] TEXT_LAST = BC_W'(2 * N_TEXT_WORDS - 1);

    state_t          state, next_state;
    logic [4:0]      leds;
    logic [BC_W-1:0] bcnt;
    logic [TO_W-1:0] to_cnt;
    logic            in_frame, timeout, take, sec_last, cmd_ok, ser_done;

    assign in_frame = state == KEY || state == TEXT;
    assign timeout  = in_frame && to_cnt == TO_LAST;
    assign take     = in_frame && rx_valid && !timeout;
    assign sec_last = bcnt == ((state == KEY) ? KEY_LAST : TEXT_LAST);
    assign cmd_ok   = rx_valid && (rx_byte == CMD_SIMON || rx_byte == CMD_SPECK);

    assign {led_output_result, led_wait_result, led_text_input, led_key_input, led_input_commande} = leds;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CMD;
            leds  <= 5'b00001;
        end else begin
            state <= next_state;
            leds  <= 5'b00001 << next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CMD:     next_state = cmd_ok ? KEY : CMD;
            KEY:     next_state = timeout ? CMD : (take && sec_last) ? TEXT : KEY;
            TEXT:    next_state = timeout ? CMD : (take && sec_last) ? WAIT : TEXT;
            WAIT:    next_state = core_done ? OUTPUT : WAIT;
            OUTPUT:  next_state = ser_done ? CMD : OUTPUT;
            default: next_state = CMD;
        endcase
    end

    // Byte i of a section lands in word i/2, half i%2; text words fill from the top down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd     <= '0;
            key     <= '0;
            text    <= '0;
            bcnt    <= '0;
            to_cnt  <= '0;
            start   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            start  <= 1'b0;
            to_cnt <= (in_frame && !rx_valid && !timeout) ? to_cnt + 1'b1 : '0;
            if ((state == WAIT || state == OUTPUT) && rx_valid)
                overrun <= 1'b1;
            if (state == CMD && cmd_ok) begin
                cmd     <= rx_byte;
                key     <= '0;
                text    <= '0;
                bcnt    <= '0;
                overrun <= 1'b0;
            end else if (take) begin
                bcnt  <= sec_last ? '0 : bcnt + 1'b1;
                start <= state == TEXT && sec_last;
                if (state == KEY) begin
                    for (int i = 0; i < 2 * N_KEY_WORDS; i++)
                        if (bcnt == BC_W'(i))
                            key[8*i +: 8] <= rx_byte;
                end else begin
                    for (int i = 0; i < 2 * N_TEXT_WORDS; i++)
                        if (bcnt == BC_W'(i))
                            text[WORD_W*(int'(N_TEXT_WORDS) - 1 - i/2) + 8*(i%2) +: 8] <= rx_byte;
                end
            end
        end
    end

    result_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (state == WAIT && core_done),
        .result   (core_result),
        .tx_ready (tx_ready),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .done     (ser_done)
    );
endmodule
